data_mem_responder: RTL and testbench

- Word-addressed data memory that serves the single-cycle MIPS core's load/store port: address from the ALU result, store data from register-file read port 2, load data back into the writeback mux.
- Adds a req/ready handshake with a configurable access latency and a stall output, so the core can be frozen while a slow memory completes an access.
- Flags misaligned word accesses instead of performing them.

---
 rtl/data_mem_responder.sv | 115 +++++++++++
 tb/tb_data_mem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with req/ready handshake,
// configurable access latency, stall and misalign flags.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            we_q;
  logic            err_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic [AW-1:0]   acc_idx;
  logic            acc_mis;
  logic            unused_addr;

  assign idx         = addr_q[AW+1:2];
  assign acc_idx     = addr[AW+1:2];
  assign acc_mis     = (addr[1:0] != 2'b00);
  assign unused_addr = ^addr[31:AW+2];

  // Core is frozen while it asks and the answer is not here yet.
  assign stall = req & ~ready;

  // Handshake FSM, latched request, memory array and response regs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready    <= 1'b0;
      misalign <= 1'b0;
      rdata    <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ready    <= 1'b0;
      misalign <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            err_q   <= acc_mis;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            if (acc_mis) begin
              state    <= RESP;
              ready    <= 1'b1;
              misalign <= 1'b1;
              rdata    <= '0;
            end else if (LATENCY == 1) begin
              state <= RESP;
              ready <= 1'b1;
              if (!we) begin
                rdata <= mem[acc_idx];
              end
            end else begin
              state <= BUSY;
              cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (!req) begin
            state <= IDLE;
          end else if (cnt == CW'(1)) begin
            state <= RESP;
            ready <= 1'b1;
            if (!we_q) begin
              rdata <= mem[idx];
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          if (we_q && !err_q) begin
            mem[idx] <= wdata_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY 1/2/3 instances checked
// against a word-array reference model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst      [3];
  logic        req      [3];
  logic        we       [3];
  logic [31:0] addr     [3];
  logic [31:0] wdata    [3];
  logic        ready    [3];
  logic [31:0] rdata    [3];
  logic        stall    [3];
  logic        misalign [3];

  logic [31:0] mem_m   [3][64];
  logic [31:0] last_rd [3];

  int n_chk  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH_WORDS(64),
      .LATENCY    (g + 1)
    ) u_dut (
      .clk     (clk),
      .reset   (rst[g]),
      .req     (req[g]),
      .we      (we[g]),
      .addr    (addr[g]),
      .wdata   (wdata[g]),
      .ready   (ready[g]),
      .rdata   (rdata[g]),
      .stall   (stall[g]),
      .misalign(misalign[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags(int d);
    return {29'd0, ready[d], misalign[d], stall[d]};
  endfunction

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_model(int d);
    for (int i = 0; i < 64; i++) mem_m[d][i] = '0;
    last_rd[d] = '0;
  endtask

  // Called at a negedge. b2b: previous access ended this
  // same negedge with req held, so DUT is in RESP now.
  task automatic access(int d, bit w, logic [31:0] a,
                        logic [31:0] wd, bit hold,
                        bit b2b, bit scram);
    int          lat;
    int          exp_n;
    int          n;
    bit          got;
    bit          mis;
    logic [5:0]  ix;
    logic [31:0] exp_rd;
    lat   = d + 1;
    mis   = (a[1:0] != 2'b00);
    exp_n = (mis ? 1 : lat) + (b2b ? 1 : 0);
    ix    = a[7:2];
    req[d]   = 1'b1;
    we[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    if (!b2b) begin
      #1;
      chk("accept_flags", flags(d), 32'd1);
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 12) begin
      @(negedge clk);
      n++;
      if (ready[d]) begin
        got = 1'b1;
      end else begin
        chk("wait_flags", flags(d), 32'd1);
        if (scram && n > (b2b ? 1 : 0)) begin
          addr[d]  = $urandom;
          wdata[d] = $urandom;
          we[d]    = 1'($urandom);
        end
      end
    end
    chk("latency", 32'(n), 32'(exp_n));
    if (mis) begin
      exp_rd = '0;
    end else if (w) begin
      exp_rd = last_rd[d];
      mem_m[d][ix] = wd;
    end else begin
      exp_rd = mem_m[d][ix];
    end
    last_rd[d] = exp_rd;
    if (got) begin
      chk("rdata", rdata[d], exp_rd);
      chk("misalign", 32'(misalign[d]), 32'(mis));
      chk("stall_at_ready", 32'(stall[d]), 32'd0);
    end
    if (!hold) req[d] = 1'b0;
  endtask

  task automatic abort_store(int d, logic [31:0] a);
    req[d]   = 1'b1;
    we[d]    = 1'b1;
    addr[d]  = a;
    wdata[d] = $urandom;
    @(negedge clk);
    chk("abort_busy_stall", 32'(stall[d]), 32'd1);
    req[d] = 1'b0;
    #1;
    chk("abort_stall", 32'(stall[d]), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_ready", flags(d), 32'd0);
    end
  endtask

  task automatic reset_store(int d, logic [31:0] a);
    req[d]   = 1'b1;
    we[d]    = 1'b1;
    addr[d]  = a;
    wdata[d] = $urandom;
    @(negedge clk);
    rst[d] = 1'b1;
    @(negedge clk);
    chk("rst_busy_flags", {29'd0, ready[d], misalign[d], 1'b0},
        32'd0);
    chk("rst_busy_rdata", rdata[d], 32'd0);
    rst[d] = 1'b0;
    req[d] = 1'b0;
    clear_model(d);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_ready", flags(d), 32'd0);
    end
  endtask

  initial begin
    bit          hold;
    bit          prev_hold;
    logic [31:0] a;
    for (int d = 0; d < 3; d++) begin
      rst[d]   = 1'b1;
      req[d]   = 1'b0;
      we[d]    = 1'b0;
      addr[d]  = '0;
      wdata[d] = '0;
      clear_model(d);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_flags", flags(d), 32'd0);
      chk("reset_rdata", rdata[d], 32'd0);
      rst[d] = 1'b0;
    end
    idle(1);

    access(1, 1'b0, 32'h3C, 32'h0, 0, 0, 0);
    idle(1);
    access(1, 1'b1, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    idle(1);
    access(1, 1'b0, 32'h10, 32'h0, 0, 0, 0);
    idle(1);
    access(1, 1'b0, 32'h13, 32'h0, 0, 0, 0);
    idle(1);
    access(1, 1'b1, 32'h11, 32'h12345678, 0, 0, 0);
    idle(1);
    access(1, 1'b0, 32'h10, 32'h0, 0, 0, 0);
    idle(1);
    access(1, 1'b1, 32'h100, 32'h55, 0, 0, 0);
    idle(1);
    access(1, 1'b0, 32'h000, 32'h0, 0, 0, 0);
    idle(1);
    abort_store(1, 32'h20);
    access(1, 1'b0, 32'h20, 32'h0, 0, 0, 0);
    idle(1);
    access(1, 1'b1, 32'h24, 32'hA5A5A5A5, 0, 0, 0);
    idle(1);
    reset_store(1, 32'h24);
    access(1, 1'b0, 32'h24, 32'h0, 0, 0, 0);
    idle(1);
    abort_store(2, 32'h28);
    access(2, 1'b0, 32'h28, 32'h0, 0, 0, 0);
    idle(1);

    for (int d = 0; d < 3; d += 2) begin
      access(d, 1'b1, 32'h40, 32'h11111111, 1, 0, 1);
      access(d, 1'b1, 32'h44, 32'h22222222, 1, 1, 1);
      access(d, 1'b0, 32'h40, 32'h0, 1, 1, 1);
      access(d, 1'b0, 32'h44, 32'h0, 1, 1, 1);
      access(d, 1'b0, 32'h45, 32'h0, 1, 1, 1);
      access(d, 1'b0, 32'h44, 32'h0, 0, 1, 1);
      idle(1);
    end

    for (int d = 0; d < 3; d++) begin
      prev_hold = 1'b0;
      for (int k = 0; k < 40; k++) begin
        a = $urandom;
        if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
        hold = (k != 39) && ($urandom_range(0, 1) == 1);
        access(d, 1'($urandom), a, $urandom, hold,
               prev_hold, 1);
        prev_hold = hold;
        if (!hold) idle(1);
      end
    end

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
